// File: rtl/gate_demux_arbiter.sv
// Round-robin sequencer that shares a demux-built NAND/NOR unit among NREQ requesters (stats: GATE_DEMUX_ARB_STATS_EN).
// Latency: gnt one cycle after capture, done four cycles after capture; one op per 5 cycles, req held until gnt.
module gate_demux_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] a_in,
    input  logic [NREQ-1:0] b_in,
    input  logic [NREQ-1:0] op_in,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            done,
    output logic [IDW-1:0]  done_id,
    output logic            result
`ifdef GATE_DEMUX_ARB_STATS_EN
    ,
    output logic [15:0]     op_count,
    output logic [15:0]     nor_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        STAGE1 = 3'd2,
        STAGE2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cap_id;
    logic           cap_a;
    logic           cap_b;
    logic           cap_op;
    logic           s1;

    logic           pick_vld;
    logic [IDW-1:0] pick_id;
    logic           and_v;
    logic           or_v;
    logic           s1_next;
    logic           stage2_y;
    logic [IDW-1:0] next_ptr;

    // 1:2 demux primitive: y1 = I & sel, y0 = I & ~sel
    function automatic logic demux_y1(input logic i, input logic sel);
        return i & sel;
    endfunction

    function automatic logic demux_y0(input logic i, input logic sel);
        return i & ~sel;
    endfunction

    // First asserted request at or above rr_ptr, wrapping past NREQ-1
    always_comb begin : rr_pick
        int j;
        pick_vld = 1'b0;
        pick_id  = '0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!pick_vld && req[j]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(j);
            end
        end
    end

    // Stage 1 plane: AND is demux(a,b).y1; OR adds the a&~b and b&~a minterms
    always_comb begin
        and_v    = demux_y1(cap_a, cap_b);
        or_v     = demux_y1(cap_a, cap_b) | demux_y0(cap_a, cap_b) | demux_y0(cap_b, cap_a);
        s1_next  = cap_op ? or_v : and_v;
        stage2_y = demux_y0(1'b1, s1);
        next_ptr = (cap_id == IDW'(NREQ - 1)) ? '0 : cap_id + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= 1'b0;
            rr_ptr  <= '0;
            s1      <= 1'b0;
            cap_id  <= '0;
            cap_a   <= 1'b0;
            cap_b   <= 1'b0;
            cap_op  <= 1'b0;
`ifdef GATE_DEMUX_ARB_STATS_EN
            op_count  <= '0;
            nor_count <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cap_id <= pick_id;
                        cap_a  <= a_in[pick_id];
                        cap_b  <= b_in[pick_id];
                        cap_op <= op_in[pick_id];
                        gnt    <= NREQ'(1) << pick_id;
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    state <= STAGE1;
                end
                STAGE1: begin
                    s1    <= s1_next;
                    state <= STAGE2;
                end
                STAGE2: begin
                    result  <= stage2_y;
                    done_id <= cap_id;
                    done    <= 1'b1;
`ifdef GATE_DEMUX_ARB_STATS_EN
                    op_count <= op_count + 16'd1;
                    if (cap_op) begin
                        nor_count <= nor_count + 16'd1;
                    end
`endif
                    state <= DONE;
                end
                DONE: begin
                    // Advance past the served requester so others win next
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_demux_arbiter.sv
// Directed bench for gate_demux_arbiter: reset, NAND/NOR sweep, round-robin order, reset mid-operation.
module tb_gate_demux_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] a_in;
    logic [NREQ-1:0] b_in;
    logic [NREQ-1:0] op_in;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic [IDW-1:0]  done_id;
    logic            result;
`ifdef GATE_DEMUX_ARB_STATS_EN
    logic [15:0]     op_count;
    logic [15:0]     nor_count;
`endif

    int total = 0;
    int bad   = 0;
    int ops   = 0;
    int nors  = 0;

    gate_demux_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .op_in   (op_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result)
`ifdef GATE_DEMUX_ARB_STATS_EN
        ,
        .op_count  (op_count),
        .nor_count (nor_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation on requester id; operands are scrambled after capture
    task automatic run_op(input int id, input logic a, input logic b, input logic op,
                          input logic exp_res, input string tag);
        req        = '0;
        req[id]    = 1'b1;
        a_in       = '0;
        b_in       = '0;
        op_in      = '0;
        a_in[id]   = a;
        b_in[id]   = b;
        op_in[id]  = op;
        tick();
        chk({tag, ".gnt"}, 32'(gnt), 32'(1 << id));
        req   = '0;
        a_in  = ~a_in;
        b_in  = ~b_in;
        op_in = ~op_in;
        tick();
        tick();
        tick();
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".res"}, 32'(result), 32'(exp_res));
        chk({tag, ".id"}, 32'(done_id), 32'(id));
        ops++;
        if (op) nors++;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        req   = '1;
        a_in  = '0;
        b_in  = '0;
        op_in = '0;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst.gnt", 32'(gnt), 32'd0);
            chk("rst.busy", 32'(busy), 32'd0);
            chk("rst.done", 32'(done), 32'd0);
            chk("rst.result", 32'(result), 32'd0);
            chk("rst.done_id", 32'(done_id), 32'd0);
        end
        rst = 1'b0;
        req = '0;
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        // Single NAND with full cycle-by-cycle timing
        req   = 4'b0001;
        a_in  = 4'b0001;
        b_in  = 4'b0001;
        op_in = 4'b0000;
        tick();
        chk("nand.gnt", 32'(gnt), 32'b0001);
        chk("nand.busy1", 32'(busy), 32'd1);
        req  = '0;
        a_in = '0;
        tick();
        chk("nand.gnt_off", 32'(gnt), 32'd0);
        chk("nand.done_early1", 32'(done), 32'd0);
        tick();
        chk("nand.done_early2", 32'(done), 32'd0);
        chk("nand.busy3", 32'(busy), 32'd1);
        tick();
        chk("nand.done", 32'(done), 32'd1);
        chk("nand.result", 32'(result), 32'd0);
        chk("nand.done_id", 32'(done_id), 32'd0);
        chk("nand.busy4", 32'(busy), 32'd1);
        ops++;
        tick();
        chk("nand.done_fall", 32'(done), 32'd0);
        chk("nand.busy_fall", 32'(busy), 32'd0);
        chk("nand.result_hold", 32'(result), 32'd0);

        // Truth-table sweep on requester 2, back to back
        run_op(2, 1'b0, 1'b0, 1'b0, 1'b1, "nand00");
        run_op(2, 1'b0, 1'b1, 1'b0, 1'b1, "nand01");
        run_op(2, 1'b1, 1'b0, 1'b0, 1'b1, "nand10");
        run_op(2, 1'b1, 1'b1, 1'b0, 1'b0, "nand11");
        run_op(2, 1'b0, 1'b0, 1'b1, 1'b1, "nor00");
        run_op(2, 1'b0, 1'b1, 1'b1, 1'b0, "nor01");
        run_op(2, 1'b1, 1'b0, 1'b1, 1'b0, "nor10");
        run_op(2, 1'b1, 1'b1, 1'b1, 1'b0, "nor11");
        chk("sweep.result_hold", 32'(result), 32'd0);

`ifdef GATE_DEMUX_ARB_STATS_EN
        chk("stats.op_count", 32'(op_count), 32'(ops));
        chk("stats.nor_count", 32'(nor_count), 32'(nors));
`endif

        // Round robin from a fresh reset with all requesters held
        rst = 1'b1;
        req = '1;
        tick();
        rst   = 1'b0;
        a_in  = 4'b1111;
        b_in  = 4'b0000;
        op_in = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr.gnt", 32'(gnt), 32'(1 << (i % 4)));
            tick();
            chk("rr.gnt_off", 32'(gnt), 32'd0);
            chk("rr.no_done_s1", 32'(done), 32'd0);
            tick();
            chk("rr.no_done_s2", 32'(done), 32'd0);
            tick();
            chk("rr.done", 32'(done), 32'd1);
            chk("rr.done_id", 32'(done_id), 32'(i % 4));
            chk("rr.result", 32'(result), 32'd1);
            tick();
            chk("rr.done_fall", 32'(done), 32'd0);
        end

        // Reset during STAGE1 abandons the op and rewinds the pointer
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("rmid.gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("rmid.done", 32'(done), 32'd0);
        chk("rmid.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req = '1;
        tick();
        chk("rmid.first_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        chk("rmid.no_stale_done1", 32'(done), 32'd0);
        tick();
        chk("rmid.no_stale_done2", 32'(done), 32'd0);
        tick();
        chk("rmid.done_id", 32'(done_id), 32'd0);
        chk("rmid.done", 32'(done), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
